// File: rtl/lsu_pkg.sv
// Shared types, size encodings and the alignment rule for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Natural alignment check; off is the byte offset within the memory word.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    unique case (size)
      SZ_HALF:  bad = off[0];
      SZ_WORD:  bad = |off[1:0];
      SZ_DWORD: bad = |off;
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-side enables/replication and load-side extract/extend.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                    size_i,
  input  logic                          unsigned_i,
  input  logic [$clog2(DATA_W/8)-1:0]   off_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W/8-1:0]           be_o,
  output logic [DATA_W-1:0]             wdata_o,
  input  logic [DATA_W-1:0]             rdata_i,
  output logic [DATA_W-1:0]             rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] shifted;

  // Move the addressed lanes down to bit 0 before extension.
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Store side: enables shifted to the lane offset, data replicated across all lanes.
  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = NB'(1) << off_i;
        wdata_o = {NB{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = NB'(3) << off_i;
        wdata_o = {(NB / 2){wdata_i[15:0]}};
      end
      SZ_WORD: begin
        be_o    = NB'(15) << off_i;
        wdata_o = {(NB / 4){wdata_i[31:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load side: sign or zero extension of the selected lanes.
  always_comb begin
    rdata_o = shifted;
    unique case (size_i)
      SZ_BYTE: rdata_o = unsigned_i ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      SZ_HALF: rdata_o = unsigned_i ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      SZ_WORD: rdata_o = unsigned_i ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory/writeback stage LSU with a req/gnt/rvalid handshake of variable latency.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic                  op_store_i,
  input  logic [1:0]            op_size_i,
  input  logic                  op_unsigned_i,
  input  logic [ADDR_W-1:0]     op_addr_i,
  input  logic [DATA_W-1:0]     op_wdata_i,
  input  logic [TAG_W-1:0]      op_tag_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  wb_valid_o,
  output logic [TAG_W-1:0]      wb_tag_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  misalign_o,
  output logic [ADDR_W-1:0]     bad_addr_o,
  output logic                  stall_o
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OW = $clog2(NB);

  lsu_state_e state_q, state_d;

  logic                store_q, uns_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TAG_W-1:0]    tag_q;
  logic                wb_valid_q, misalign_q;
  logic [TAG_W-1:0]    wb_tag_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [ADDR_W-1:0]   bad_addr_q;

  logic                accept, op_mis, rsp;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   ld_data;

  assign op_ready_o = (state_q == StIdle);
  assign accept     = op_valid_i & op_ready_o;
  // A dword access cannot exist on a 32-bit bus.
  assign op_mis     = misaligned(op_size_i, 3'(op_addr_i[OW-1:0])) |
                      ((DATA_W == 32) && (op_size_i == SZ_DWORD));
  // Responses only count while waiting for one; early or stale rvalid is dropped.
  assign rsp        = (state_q == StWaitR) & mem_rvalid_i;

  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .off_i     (addr_q[OW-1:0]),
    .wdata_i   (wdata_q),
    .be_o      (be),
    .wdata_o   (mem_wdata_o),
    .rdata_i   (mem_rdata_i),
    .rdata_o   (ld_data)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !op_mis) state_d = StReq;
      StReq:   if (mem_gnt_i) state_d = store_q ? StIdle : StWaitR;
      StWaitR: if (mem_rvalid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Capture operation fields on a legal accept; they stay put through the access.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else if (accept && !op_mis) begin
      store_q <= op_store_i;
      uns_q   <= op_unsigned_i;
      size_q  <= op_size_i;
      addr_q  <= op_addr_i;
      wdata_q <= op_wdata_i;
      tag_q   <= op_tag_i;
    end
  end

  // Writeback and exception pulses, registered one cycle after their cause.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      wb_valid_q <= rsp;
      misalign_q <= accept & op_mis;
      if (rsp) begin
        wb_tag_q  <= tag_q;
        wb_data_q <= ld_data;
      end
      if (accept && op_mis) bad_addr_q <= op_addr_i;
    end
  end

  assign mem_req_o  = (state_q == StReq);
  assign mem_we_o   = mem_req_o & store_q;
  assign mem_be_o   = mem_req_o ? be : '0;
  assign mem_addr_o = addr_q & ~ADDR_W'(NB - 1);
  assign wb_valid_o = wb_valid_q;
  assign wb_tag_o   = wb_tag_q;
  assign wb_data_o  = wb_data_q;
  assign misalign_o = misalign_q;
  assign bad_addr_o = bad_addr_q;
  assign stall_o    = (state_q != StIdle) | (op_valid_i & ~op_ready_o);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench: vector table plus hand sequences; loads scored via a queue.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 32-bit instance
  logic        op_valid, op_ready, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic [4:0]  op_tag;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, misalign, stall;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data, bad_addr;

  // 64-bit instance
  logic        op_valid64, op_ready64, op_unsigned64;
  logic [1:0]  op_size64;
  logic [31:0] op_addr64;
  logic [4:0]  op_tag64;
  logic        mem_req64, mem_we64, mem_gnt64, mem_rvalid64;
  logic [31:0] mem_addr64;
  logic [63:0] mem_wdata64, mem_rdata64, wb_data64;
  logic [7:0]  mem_be64;
  logic        wb_valid64, misalign64, stall64;
  logic [4:0]  wb_tag64;
  logic [31:0] bad_addr64;

  lsu_mem_stage #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut (
    .clk_i(clk), .reset_i(reset), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_store_i(op_store), .op_size_i(op_size), .op_unsigned_i(op_unsigned),
    .op_addr_i(op_addr), .op_wdata_i(op_wdata), .op_tag_i(op_tag),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid), .wb_tag_o(wb_tag), .wb_data_o(wb_data),
    .misalign_o(misalign), .bad_addr_o(bad_addr), .stall_o(stall)
  );

  lsu_mem_stage #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk_i(clk), .reset_i(reset), .op_valid_i(op_valid64), .op_ready_o(op_ready64),
    .op_store_i(1'b0), .op_size_i(op_size64), .op_unsigned_i(op_unsigned64),
    .op_addr_i(op_addr64), .op_wdata_i(64'h0), .op_tag_i(op_tag64),
    .mem_req_o(mem_req64), .mem_we_o(mem_we64), .mem_addr_o(mem_addr64),
    .mem_be_o(mem_be64), .mem_wdata_o(mem_wdata64), .mem_gnt_i(mem_gnt64),
    .mem_rvalid_i(mem_rvalid64), .mem_rdata_i(mem_rdata64), .wb_valid_o(wb_valid64),
    .wb_tag_o(wb_tag64), .wb_data_o(wb_data64), .misalign_o(misalign64),
    .bad_addr_o(bad_addr64), .stall_o(stall64)
  );

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        early;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] wb;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every writeback must match the oldest outstanding load.
  always @(negedge clk) begin
    if (wb_valid) begin
      chk("mis_wb_excl", {63'd0, misalign}, 64'd0);
      if (sb.size() == 0) begin
        chk("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_tag", {59'd0, wb_tag}, {59'd0, e.tag});
        chk("wb_data", {32'd0, wb_data}, {32'd0, e.data});
      end
    end
  end

  task automatic issue(input vec_t v, input logic [4:0] tag);
    op_valid    = 1'b1;
    op_store    = v.st;
    op_size     = v.size;
    op_unsigned = v.uns;
    op_addr     = v.addr;
    op_wdata    = v.wdata;
    op_tag      = tag;
    chk("op_ready", {63'd0, op_ready}, 64'd1);
    if (!v.st && !v.mis) sb.push_back('{tag, v.wb});
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic serve(input vec_t v);
    chk("mem_req", {63'd0, mem_req}, 64'd1);
    chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr & ~32'd3});
    chk("mem_be", {60'd0, mem_be}, {60'd0, v.be});
    chk("mem_we", {63'd0, mem_we}, {63'd0, v.st});
    if (v.st) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.mwdata});
    for (int d = 0; d < v.dly; d++) begin
      @(negedge clk);
      chk("req_hold", {63'd0, mem_req}, 64'd1);
      chk("addr_hold", {32'd0, mem_addr}, {32'd0, v.addr & ~32'd3});
      chk("stall_hold", {63'd0, stall}, 64'd1);
    end
    mem_gnt = 1'b1;
    if (v.early) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("req_drop", {63'd0, mem_req}, 64'd0);
    if (v.st) begin
      chk("st_idle", {63'd0, stall}, 64'd0);
    end else begin
      chk("wait_stall", {63'd0, stall}, 64'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("wb_valid", {63'd0, wb_valid}, 64'd1);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] tag);
    issue(v, tag);
    if (v.mis) begin
      chk("misalign", {63'd0, misalign}, 64'd1);
      chk("bad_addr", {32'd0, bad_addr}, {32'd0, v.addr});
      chk("mis_noreq", {63'd0, mem_req}, 64'd0);
      chk("mis_ready", {63'd0, op_ready}, 64'd1);
      @(negedge clk);
      chk("mis_pulse", {63'd0, misalign}, 64'd0);
      chk("bad_hold", {32'd0, bad_addr}, {32'd0, v.addr});
      chk("mis_noreq2", {63'd0, mem_req}, 64'd0);
    end else begin
      serve(v);
    end
  endtask

  task automatic load64(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [63:0] rdata, input logic [7:0] be,
                        input logic [63:0] wb, input logic [4:0] tag);
    op_valid64    = 1'b1;
    op_addr64     = addr;
    op_size64     = size;
    op_unsigned64 = uns;
    op_tag64      = tag;
    chk("op_ready64", {63'd0, op_ready64}, 64'd1);
    @(negedge clk);
    op_valid64 = 1'b0;
    chk("mem_req64", {63'd0, mem_req64}, 64'd1);
    chk("misalign64", {63'd0, misalign64}, 64'd0);
    chk("mem_addr64", {32'd0, mem_addr64}, {32'd0, addr & ~32'd7});
    chk("mem_be64", {56'd0, mem_be64}, {56'd0, be});
    mem_gnt64 = 1'b1;
    @(negedge clk);
    mem_gnt64 = 1'b0;
    chk("wb_early64", {63'd0, wb_valid64}, 64'd0);
    mem_rvalid64 = 1'b1;
    mem_rdata64  = rdata;
    @(negedge clk);
    mem_rvalid64 = 1'b0;
    chk("wb_valid64", {63'd0, wb_valid64}, 64'd1);
    chk("wb_data64", wb_data64, wb);
    chk("wb_tag64", {59'd0, wb_tag64}, {59'd0, tag});
  endtask

  vec_t tbl[13];
  vec_t va, vb;

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    op_addr = '0; op_wdata = '0; op_tag = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    op_valid64 = 1'b0; op_size64 = 2'd0; op_unsigned64 = 1'b0; op_addr64 = '0;
    op_tag64 = '0; mem_gnt64 = 1'b0; mem_rvalid64 = 1'b0; mem_rdata64 = '0;

    //          st    size      uns   addr     wdata          rdata          dly early mis  be       mwdata         wb
    tbl[0]  = '{1'b0, SZ_BYTE,  1'b0, 32'h103, 32'h0,         32'h80FF_0000, 2, 1'b0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[1]  = '{1'b0, SZ_BYTE,  1'b1, 32'h103, 32'h0,         32'h80FF_0000, 2, 1'b0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
    tbl[2]  = '{1'b1, SZ_HALF,  1'b0, 32'h022, 32'h0000_1234, 32'h0,         1, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 32'h0};
    tbl[3]  = '{1'b0, SZ_WORD,  1'b0, 32'h006, 32'h0,         32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, SZ_DWORD, 1'b0, 32'h008, 32'h0,         32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, SZ_HALF,  1'b0, 32'h006, 32'h0,         32'hBEEF_0000, 0, 1'b1, 1'b0, 4'b1100, 32'h0,         32'hFFFF_BEEF};
    tbl[6]  = '{1'b0, SZ_HALF,  1'b1, 32'h004, 32'h0,         32'h1234_9ABC, 1, 1'b0, 1'b0, 4'b0011, 32'h0,         32'h0000_9ABC};
    tbl[7]  = '{1'b1, SZ_BYTE,  1'b0, 32'h041, 32'h0000_00A5, 32'h0,         0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{1'b1, SZ_WORD,  1'b0, 32'h080, 32'hDEAD_BEEF, 32'h0,         3, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b0, SZ_HALF,  1'b0, 32'h005, 32'h0,         32'h0,         0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[10] = '{1'b0, SZ_WORD,  1'b0, 32'h200, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
    tbl[11] = '{1'b0, SZ_BYTE,  1'b0, 32'h000, 32'h0,         32'h0000_007F, 0, 1'b0, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};
    tbl[12] = '{1'b0, SZ_WORD,  1'b0, 32'h010, 32'h0,         32'h0A0B_0C0D, 0, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h0A0B_0C0D};

    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_be", {60'd0, mem_be}, 64'd0);
    chk("rst_wb", {63'd0, wb_valid}, 64'd0);
    chk("rst_mis", {63'd0, misalign}, 64'd0);
    chk("rst_bad", {32'd0, bad_addr}, 64'd0);
    chk("rst_wbdata", {32'd0, wb_data}, 64'd0);
    chk("rst_wbtag", {59'd0, wb_tag}, 64'd0);
    chk("rst_ready", {63'd0, op_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 5'(i + 1));

    // Back-to-back: B is presented in the cycle A's writeback pulses.
    va = '{1'b0, SZ_WORD, 1'b0, 32'h040, 32'h0, 32'h1122_3344, 0, 1'b0, 1'b0, 4'b1111, 32'h0,
           32'h1122_3344};
    vb = '{1'b0, SZ_HALF, 1'b0, 32'h042, 32'h0, 32'h8001_0000, 2, 1'b0, 1'b0, 4'b1100, 32'h0,
           32'hFFFF_8001};
    run_vec(va, 5'd20);
    run_vec(vb, 5'd21);

    // Reset while in REQ: request drops asynchronously.
    issue(tbl[12], 5'd9);
    chk("pre_rst_req", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_req_async", {63'd0, mem_req}, 64'd0);
    chk("rst_ready_async", {63'd0, op_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();

    // Reset while in WAIT_R, then a late response that must be ignored.
    issue(tbl[12], 5'd10);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("waitr_stall", {63'd0, stall}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_stall_async", {63'd0, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_wb", {63'd0, wb_valid}, 64'd0);
    chk("late_wbdata", {32'd0, wb_data}, 64'd0);
    chk("late_wbtag", {59'd0, wb_tag}, 64'd0);
    chk("late_bad", {32'd0, bad_addr}, 64'd0);
    chk("late_be", {60'd0, mem_be}, 64'd0);
    chk("late_ready", {63'd0, op_ready}, 64'd1);
    run_vec(tbl[12], 5'd11);

    // 64-bit bus: dword with zero wait states, then sub-word lanes in the upper half.
    load64(32'h08, SZ_DWORD, 1'b0, 64'h8877_6655_4433_2211, 8'hFF, 64'h8877_6655_4433_2211, 5'd1);
    load64(32'h0C, SZ_WORD, 1'b0, 64'h8000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0001, 5'd2);
    load64(32'h0F, SZ_BYTE, 1'b1, 64'hF000_0000_0000_0000, 8'h80, 64'h0000_0000_0000_00F0, 5'd3);

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised load/store unit for the memory/writeback stage of the MIPS150 pipeline. It replaces the fixed 32-bit, single-cycle DMEM access path with a request/grant/response memory handshake of variable latency. It provides byte-lane write enables, load extraction with sign or zero extension, and misalignment detection. It stalls the pipeline while an access is outstanding and returns load results with a destination-register tag for writeback.

## Interface
- `DATA_W`, 32: memory word width; must be 32 or 64.
- `ADDR_W`, 32: byte address width.
- `TAG_W`, 5: writeback register tag width.
- `CLK` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `op_valid` input 1: memory operation presented.
- `op_ready` output 1: unit can accept an operation this cycle.
- `op_store` input 1: 1 = store, 0 = load.
- `op_size` input 2: access size; 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when `DATA_W`=64).
- `op_unsigned` input 1: zero-extend the load (LBU/LHU); ignored for stores.
- `op_addr` input `ADDR_W`: byte address.
- `op_wdata` input `DATA_W`: store data, right-justified.
- `op_tag` input `TAG_W`: destination register for loads.
- `mem_req` output 1: memory request.
- `mem_we` output 1: request is a write.
- `mem_addr` output `ADDR_W`: word-aligned address; the low log2(`DATA_W`/8) bits are zero.
- `mem_be` output `DATA_W`/8: byte enables.
- `mem_wdata` output `DATA_W`: lane-replicated store data.
- `mem_gnt` input 1: request accepted.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input `DATA_W`: read data.
- `wb_valid` output 1: load result valid, one-cycle pulse.
- `wb_tag` output `TAG_W`: tag of the returned load.
- `wb_data` output `DATA_W`: extended load result.
- `misalign` output 1: one-cycle exception pulse.
- `bad_addr` output `ADDR_W`: faulting address; holds its value until the next misalign.
- `stall` output 1: pipeline stall request.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- `op_ready` = (state == IDLE). An operation is accepted when `op_valid` and `op_ready` are both high.
- At accept, all operation fields are registered and the lane offset `off` = `op_addr` modulo (`DATA_W`/8) is computed.
- Misalignment conditions:
  - half access with `off[0]` set;
  - word access with `off[1:0]` nonzero;
  - dword access with `off` nonzero;
  - `op_size`=3 when `DATA_W`=32.
- A misaligned operation makes no memory access. `misalign` pulses the next cycle, `bad_addr` is loaded, and the state stays IDLE.
- A legal operation moves to REQ. In REQ, `mem_req` stays high and every `mem_*` output stays stable until `mem_gnt`.
- Byte lanes are little-endian: byte k of the word is bits [8k+7:8k].
- Byte enables:
  - byte: `mem_be` = 1<<off;
  - half: `mem_be` = 2'b11<<off;
  - word: `mem_be` = 4'hF<<off;
  - dword: `mem_be` all ones.
- `mem_wdata` replicates the low byte, half or word of `op_wdata` across every lane.
- Store: on `mem_gnt` the state returns to IDLE; no writeback occurs.
- Load: on `mem_gnt` the state moves to WAIT_R.
- In WAIT_R, on `mem_rvalid` the state returns to IDLE. On the following edge `wb_valid`=1, and `wb_data` holds the selected lanes sign-extended, or zero-extended if `op_unsigned` is set.
- `mem_rvalid` is ignored outside WAIT_R. This covers `mem_rvalid` arriving in the same cycle as `mem_gnt`, and stale responses arriving after a reset.
- `stall` = (state != IDLE) OR (`op_valid` AND NOT `op_ready`).

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_be`=0, `wb_valid`=0, `misalign`=0, `bad_addr`=0, `wb_data`=0, `wb_tag`=0. `op_ready`=1 and `stall` follows `op_valid`&&!`op_ready`.
- Accept at cycle 0 gives `mem_req`=1 at cycle 1.
- With zero wait states (`mem_gnt` at cycle 1, `mem_rvalid` at cycle 2), `wb_valid` is at cycle 3. Minimum load latency is therefore 3 cycles; minimum store occupancy is 2 cycles.
- A new operation may be accepted in the same cycle `wb_valid` pulses for the previous load.
- Reset asserted in REQ or WAIT_R: `mem_req` drops immediately (asynchronous), the in-flight operation is abandoned, and no `wb_valid` is produced.
- `misalign` and `wb_valid` are never high in the same cycle.

## Structure
- `lsu_pkg` holds:
  - the state enum;
  - the size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - the `misaligned(size, off)` function.
- Sub-module `lsu_lane_align`, purely combinational and parametrised by `DATA_W`. It contains the store-side `mem_be`/`mem_wdata` generation and the load-side extraction and extension. The FSM stays in the top level.

## Test plan
- `DATA_W`=32, LB at addr 0x103 with `mem_rdata`=0x80FF_0000 after a 2-cycle `mem_gnt` delay -> `wb_data`=0xFFFF_FF80, `mem_addr`=0x100. The same access as LBU -> 0x0000_0080.
- SH of 0x1234 at addr 0x22 -> `mem_be`=4'b1100, `mem_wdata`=0x1234_1234, `mem_we`=1, no `wb_valid`.
- LW at addr 0x06 -> `misalign` pulse, `bad_addr`=0x06, `mem_req` never rises, `op_ready` high the next cycle.
- `DATA_W`=64, dword load at 0x08 with zero wait states -> `wb_valid` exactly 3 cycles after accept. `op_size`=3 with `DATA_W`=32 -> `misalign`.
- Reset asserted in WAIT_R, then a late `mem_rvalid` -> no `wb_valid`; outputs at reset values; the next LW at 0x10 completes normally.
- Back-to-back: a load is accepted in the cycle `wb_valid` pulses for the previous load; `stall` stays high while held off by a `mem_gnt` delay.
